// File: rtl/croc_obi_cache_adapter.sv
// -----------------------------------------------------------------------------
// croc_obi_cache_adapter
//
// OBI subordinate front-end for the key/value cache core. Software writes a
// KEY and a multi-word VALUE into a small register file, then writes CMD to
// launch a GET/PUT/DEL on the cache core handshake. STATUS reports busy, hit,
// timeout and bad_cmd. A watchdog aborts a command that never completes.
//
// Register map (word index = addr_i[$clog2(NV+3)+1:2]):
//   0          KEY
//   1..NV      VALUE words, least significant word first
//   NV+1       CMD (write-only, reads 0)
//   NV+2       STATUS (read-only): [0] busy [1] hit [2] timeout [3] bad_cmd
//   above      error response
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   req_i/gnt_o/addr_i/we_i/be_i/wdata_i   OBI request channel
//   rvalid_o/rdata_o/err_o         OBI response channel (one cycle after grant)
//   cache_req_o/cache_ready_i      command handshake towards the cache core
//   cache_op_o/cache_key_o/cache_wdata_o   command payload (1 GET, 2 PUT, 3 DEL)
//   cache_done_i/cache_hit_i/cache_rdata_i completion pulse with result
// -----------------------------------------------------------------------------
module croc_obi_cache_adapter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned KEY_WIDTH      = 32,
  parameter int unsigned VALUE_WIDTH    = 64,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [31:0]             addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic                    cache_req_o,
  input  logic                    cache_ready_i,
  output logic [1:0]              cache_op_o,
  output logic [KEY_WIDTH-1:0]    cache_key_o,
  output logic [VALUE_WIDTH-1:0]  cache_wdata_o,
  input  logic                    cache_done_i,
  input  logic                    cache_hit_i,
  input  logic [VALUE_WIDTH-1:0]  cache_rdata_i
);

  localparam int unsigned NV    = VALUE_WIDTH / DATA_WIDTH;
  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = $clog2(NV + 3);
  // Counter only needs to reach TIMEOUT_CYCLES-1; the final step is the abort.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [IDX_W-1:0] IDX_KEY    = '0;
  localparam logic [IDX_W-1:0] IDX_CMD    = IDX_W'(NV + 1);
  localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(NV + 2);
  localparam logic [1:0]       OP_GET     = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e                 state_reg;
  logic [KEY_WIDTH-1:0]   key_reg;
  logic [DATA_WIDTH-1:0]  value_reg [NV];
  logic                   hit_reg;
  logic                   timeout_reg;
  logic                   bad_cmd_reg;
  logic [1:0]             op_reg;
  logic                   cache_req_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   rvalid_reg;
  logic                   err_reg;
  logic [DATA_WIDTH-1:0]  rdata_reg;

  logic [IDX_W-1:0]       idx;
  logic                   busy;
  logic                   accept;
  logic                   wr_ok;
  logic [DATA_WIDTH-1:0]  be_mask;
  logic [DATA_WIDTH-1:0]  key_wide;
  logic [DATA_WIDTH-1:0]  key_merged;
  logic [DATA_WIDTH-1:0]  status_word;
  logic                   err_next;
  logic [DATA_WIDTH-1:0]  rdata_next;
  logic                   unused_addr;

  assign idx         = addr_i[IDX_W+1:2];
  assign unused_addr = ^{addr_i[31:IDX_W+2], addr_i[1:0]};

  // Byte-enable expansion into a bit mask.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_be_mask
      assign be_mask[gi*8 +: 8] = {8{be_i[gi]}};
    end
    for (genvar gi = 0; gi < NV; gi++) begin : g_wdata
      assign cache_wdata_o[gi*DATA_WIDTH +: DATA_WIDTH] = value_reg[gi];
    end
  endgenerate

  assign busy   = (state_reg != ST_IDLE);
  // A pending response blocks the next grant: single outstanding transaction.
  assign gnt_o  = req_i & ~rvalid_reg;
  assign accept = req_i & gnt_o;

  always_comb begin
    key_wide                  = '0;
    key_wide[KEY_WIDTH-1:0]   = key_reg;
    key_merged                = (key_wide & ~be_mask) | (wdata_i & be_mask);
    status_word               = '0;
    status_word[3:0]          = {bad_cmd_reg, timeout_reg, hit_reg, busy};
  end

  // Response decode from the current (pre-update) register contents.
  always_comb begin
    err_next   = 1'b0;
    rdata_next = '0;
    if (idx > IDX_STATUS) begin
      err_next = 1'b1;
    end else if (we_i) begin
      err_next = (idx == IDX_STATUS) | busy;
    end else begin
      if (idx == IDX_KEY)    rdata_next = key_wide;
      if (idx == IDX_STATUS) rdata_next = status_word;
      for (int k = 0; k < NV; k++) begin
        if (idx == IDX_W'(k + 1)) rdata_next = value_reg[k];
      end
    end
  end

  assign wr_ok = accept & we_i & ~err_next;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= ST_IDLE;
      key_reg       <= '0;
      for (int k = 0; k < NV; k++) value_reg[k] <= '0;
      hit_reg       <= 1'b0;
      timeout_reg   <= 1'b0;
      bad_cmd_reg   <= 1'b0;
      op_reg        <= 2'd0;
      cache_req_reg <= 1'b0;
      cnt_reg       <= '0;
      rvalid_reg    <= 1'b0;
      err_reg       <= 1'b0;
      rdata_reg     <= '0;
    end else begin
      rvalid_reg <= accept;
      err_reg    <= accept & err_next;
      rdata_reg  <= (accept & ~we_i & ~err_next) ? rdata_next : '0;

      // Register writes are only possible while idle (wr_ok excludes busy),
      // so they never collide with a GET completion updating VALUE.
      if (wr_ok && idx == IDX_KEY) key_reg <= key_merged[KEY_WIDTH-1:0];
      for (int k = 0; k < NV; k++) begin
        if (wr_ok && idx == IDX_W'(k + 1))
          value_reg[k] <= (value_reg[k] & ~be_mask) | (wdata_i & be_mask);
      end
      if (wr_ok && idx == IDX_CMD && be_i[0]) begin
        if (wdata_i[1:0] == 2'd0) begin
          bad_cmd_reg <= 1'b1;
        end else begin
          op_reg        <= wdata_i[1:0];
          hit_reg       <= 1'b0;
          timeout_reg   <= 1'b0;
          bad_cmd_reg   <= 1'b0;
          cache_req_reg <= 1'b1;
          state_reg     <= ST_ISSUE;
        end
      end

      case (state_reg)
        ST_ISSUE: begin
          if (cache_ready_i) begin
            state_reg     <= ST_WAIT;
            cache_req_reg <= 1'b0;
            cnt_reg       <= '0;
          end
        end
        ST_WAIT: begin
          // Completion has priority over the watchdog in the final cycle.
          if (cache_done_i) begin
            state_reg <= ST_IDLE;
            hit_reg   <= cache_hit_i;
            if (op_reg == OP_GET && cache_hit_i) begin
              for (int k = 0; k < NV; k++)
                value_reg[k] <= cache_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
          end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_reg   <= ST_IDLE;
            timeout_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rvalid_o    = rvalid_reg;
  assign err_o       = err_reg;
  assign rdata_o     = rdata_reg;
  assign cache_req_o = cache_req_reg;
  assign cache_op_o  = op_reg;
  assign cache_key_o = key_reg;

endmodule
